// File: rtl/cpu_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cpu_uart_rx                                                   |
// | Brief    : 8N1 UART receiver with byte FIFO and RTS flow control.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module cpu_uart_rx #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 1_000_000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_rts,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_pop,
  output logic       framing_error,
  output logic       overrun,
  input  logic       clear_errors
);

  localparam int c_BIT_CYCLES = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int c_CNT_W      = $clog2(c_BIT_CYCLES + 1);
  localparam int c_AW         = $clog2(FIFO_DEPTH);
  localparam int c_PW         = c_AW + 1;
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_BIT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_BIT_CYCLES / 2 - 1);
  localparam logic [c_PW-1:0]    c_RTS_LEVEL = c_PW'(FIFO_DEPTH - 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rxd_meta;
  logic                r_rxd_s;
  logic [c_CNT_W-1:0]  r_baud_cnt;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                w_cnt_clr;
  logic                w_bit_clr;
  logic                w_shift_en;
  logic                w_push;
  logic                w_frame_err;

  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]     r_wr_ptr;
  logic [c_PW-1:0]     r_rd_ptr;
  logic [c_PW-1:0]     w_count;
  logic                w_empty;
  logic                w_full;
  logic                w_do_pop;
  logic                w_do_push;
  logic                r_rts;
  logic                r_framing_error;
  logic                r_overrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxd_meta <= 1'b1;
      r_rxd_s    <= 1'b1;
    end else begin
      r_rxd_meta <= uart_rxd;
      r_rxd_s    <= r_rxd_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_clr) r_baud_cnt <= '0;
      else           r_baud_cnt <= r_baud_cnt + 1'b1;
      if (w_bit_clr)       r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_shift_en) r_shift <= {r_rxd_s, r_shift[7:1]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_bit_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!r_rxd_s) w_state_nxt = S_START;
      end
      S_START: begin
        // Mid-start-bit recheck rejects glitches shorter than half a bit.
        if (r_baud_cnt == c_HALF_LAST) begin
          w_cnt_clr = 1'b1;
          if (r_rxd_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_bit_clr   = 1'b1;
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (r_baud_cnt == c_BIT_LAST) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_baud_cnt == c_BIT_LAST) begin
          w_cnt_clr = 1'b1;
          if (r_rxd_s) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_err = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        w_cnt_clr = 1'b1;
        if (r_rxd_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                     (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
  assign w_do_pop  = rx_pop && !w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_push = w_push && (!w_full || w_do_pop);
  assign w_count   = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_rts           <= 1'b1;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_rts <= (w_count >= c_RTS_LEVEL);
      if (clear_errors) begin
        r_framing_error <= 1'b0;
        r_overrun       <= 1'b0;
      end else begin
        if (w_frame_err)                       r_framing_error <= 1'b1;
        if (w_push && w_full && !w_do_pop)     r_overrun       <= 1'b1;
      end
    end
  end

  assign uart_rts      = r_rts;
  assign rx_valid      = !w_empty;
  assign rx_data       = r_mem[r_rd_ptr[c_AW-1:0]];
  assign framing_error = r_framing_error;
  assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_cpu_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cpu_uart_rx                                                |
// | Brief    : Self-checking bench for cpu_uart_rx with a queue-based model. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_cpu_uart_rx;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rxd;
  logic       uart_rts;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_pop;
  logic       framing_error;
  logic       overrun;
  logic       clear_errors;

  int checks = 0;
  int errors = 0;

  byte unsigned mq[$];
  bit           m_ferr;
  bit           m_ovr;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         bc;
    bit         e_valid;
    logic [7:0] e_data;
    bit         e_ferr;
    bit         e_ovr;
    bit         e_rts;
  } vec_t;

  vec_t vt[4];

  always #5 clk = ~clk;

  cpu_uart_rx dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rxd      (uart_rxd),
    .uart_rts      (uart_rts),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_pop        (rx_pop),
    .framing_error (framing_error),
    .overrun       (overrun),
    .clear_errors  (clear_errors)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)               m_ferr = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(b);
    else                        m_ovr = 1'b1;
  endtask

  task automatic check_model(input string name);
    chk({name, "_valid"}, rx_valid, mq.size() > 0);
    if (mq.size() > 0) chk({name, "_data"}, rx_data, mq[0]);
    chk({name, "_ferr"}, framing_error, m_ferr);
    chk({name, "_ovr"}, overrun, m_ovr);
    chk({name, "_rts"}, uart_rts, mq.size() >= DEPTH - 2);
  endtask

  // pop_at: edge index (counted from the start edge) whose write should coincide with rx_pop.
  task automatic drive_frame(input logic [7:0] b, input bit stop_ok, input int bc,
                             input int pop_at, input int rst_at);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10 * bc; i++) begin
      if (i % bc == 0) uart_rxd = bits[i / bc];
      if (pop_at > 0) rx_pop = (i == pop_at - 1);
      if (rst_at > 0) reset = (i >= rst_at) && (i < rst_at + 3);
      tick();
    end
    uart_rxd = 1'b1;
    rx_pop   = 1'b0;
    repeat (6) tick();
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok, input int bc);
    drive_frame(b, stop_ok, bc, 0, 0);
    model_frame(b, stop_ok);
  endtask

  task automatic pop_check(input string name);
    chk({name, "_pvalid"}, rx_valid, 1);
    chk({name, "_pdata"}, rx_data, mq[0]);
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    void'(mq.pop_front());
  endtask

  task automatic clear_flags();
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{8'hA5, 1'b1, 100, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'h55, 1'b0, 100, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vt[2] = '{8'h3C, 1'b1,  96, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vt[3] = '{8'h12, 1'b1, 104, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; uart_rxd = 1'b1; rx_pop = 1'b0; clear_errors = 1'b0;
    m_ferr = 1'b0; m_ovr = 1'b0;
    repeat (3) tick();
    chk("rst_rts", uart_rts, 1);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr", framing_error, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;
    tick();
    chk("rel_rts", uart_rts, 0);

    for (int i = 0; i < 4; i++) begin
      send(vt[i].data, vt[i].stop_ok, vt[i].bc);
      chk("tbl_valid", rx_valid, vt[i].e_valid);
      chk("tbl_data", rx_data, vt[i].e_data);
      chk("tbl_ferr", framing_error, vt[i].e_ferr);
      chk("tbl_ovr", overrun, vt[i].e_ovr);
      chk("tbl_rts", uart_rts, vt[i].e_rts);
    end
    pop_check("tbl_a5");
    pop_check("tbl_3c");
    pop_check("tbl_12");
    chk("pop_empty_valid", rx_valid, 0);
    clear_flags();
    chk("clear_ferr", framing_error, 0);

    uart_rxd = 1'b0;
    repeat (30) tick();
    uart_rxd = 1'b1;
    repeat (100) tick();
    check_model("glitch");
    send(8'h3C, 1'b1, 100);
    check_model("after_glitch");
    pop_check("after_glitch");

    uart_rxd = 1'b0;
    repeat (2000) tick();
    uart_rxd = 1'b1;
    repeat (20) tick();
    m_ferr = 1'b1;
    check_model("break");
    send(8'h12, 1'b1, 100);
    check_model("after_break");
    pop_check("after_break");
    clear_flags();
    check_model("break_clear");

    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    tick();
    check_model("pop_while_empty");
    send(8'h5A, 1'b1, 100);
    check_model("after_empty_pop");
    pop_check("after_empty_pop");
    tick();

    for (int k = 0; k < 9; k++) begin
      send(8'(k), 1'b1, 100);
      chk("ovr_rts_level", uart_rts, (k + 1) >= 6);
    end
    check_model("overrun");
    for (int k = 0; k < 8; k++) begin
      chk("drain_order", rx_data, k);
      pop_check("drain");
    end
    tick();
    check_model("drained");
    clear_flags();

    for (int k = 0; k < 8; k++) send(8'($urandom), 1'b1, 100);
    check_model("full");
    drive_frame(8'h99, 1'b1, 100, 953, 0);
    void'(mq.pop_front());
    model_frame(8'h99, 1'b1);
    check_model("push_pop_full");
    for (int k = 0; k < 8; k++) pop_check("bnd_drain");
    chk("bnd_ovr", overrun, 0);
    tick();
    check_model("bnd_empty");

    send(8'h77, 1'b1, 100);
    drive_frame(8'hF0, 1'b1, 100, 0, 550);
    mq.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    check_model("reset_mid");
    send(8'h81, 1'b1, 100);
    check_model("after_reset");
    pop_check("after_reset");
    tick();

    for (int n = 0; n < 16; n++) begin
      int npop;
      send(8'($urandom), $urandom_range(0, 7) != 0, int'($urandom_range(96, 104)));
      check_model("rnd_frame");
      npop = int'($urandom_range(0, 2));
      for (int p = 0; p < npop; p++) if (mq.size() > 0) pop_check("rnd_pop");
      if ($urandom_range(0, 3) == 0) clear_flags();
      tick();
      check_model("rnd_after");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
